// File: rtl/ifetch_ctrl.sv
// ifetch_ctrl: instruction-fetch controller between the PC register and decode.
//
// Takes the current PC, runs a req/ack transaction against instruction memory,
// holds the fetched word for decode until it is accepted, then drives the PC
// write port so the PC advances by 4 or jumps to a redirect target.
// Misaligned PCs and memory timeouts put the block into a sticky fault state
// that only reset clears.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   pc_addr                current PC (from the PC register)
//   pcW, next_pc           PC write enable and value (combinational)
//   imem_req, imem_addr    memory request and address (combinational)
//   imem_ack, imem_rdata   memory response and instruction word
//   redirect, redirect_addr branch/jump taken and its target
//   stall                  decode not ready
//   instr, instr_pc        fetched instruction and its PC (registered)
//   instr_valid            instr/instr_pc valid (registered)
//   fault                  sticky fault flag (registered)

module ifetch_ctrl #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_addr,
    output logic        pcW,
    output logic [31:0] next_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_addr,
    input  logic        stall,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    output logic        fault
);

    // Wide enough to hold TIMEOUT itself.
    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] StFetch = 2'd0;
    localparam logic [1:0] StReq   = 2'd1;
    localparam logic [1:0] StValid = 2'd2;
    localparam logic [1:0] StFault = 2'd3;

    logic [1:0]      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [CntW-1:0] cnt_inc;
    logic            latch_instr;
    logic [31:0]     instr_q;
    logic [31:0]     instr_pc_q;
    logic            instr_valid_q;
    logic            fault_q;

    assign cnt_inc = cnt_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        latch_instr = 1'b0;
        pcW         = 1'b0;
        imem_req    = 1'b0;

        case (state_q)
            StFetch: begin
                if (redirect) begin
                    pcW = 1'b1;
                end else if (pc_addr[1:0] != 2'b00) begin
                    state_d = StFault;
                end else begin
                    state_d = StReq;
                    cnt_d   = '0;
                end
            end
            StReq: begin
                imem_req = 1'b1;
                if (redirect) begin
                    // A same-cycle ack is dropped: the fetched word belongs to the old path.
                    pcW     = 1'b1;
                    state_d = StFetch;
                end else if (imem_ack) begin
                    latch_instr = 1'b1;
                    state_d     = StValid;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CntW'(TIMEOUT)) begin
                        state_d = StFault;
                    end
                end
            end
            StValid: begin
                if (redirect) begin
                    pcW     = 1'b1;
                    state_d = StFetch;
                end else if (!stall) begin
                    pcW     = 1'b1;
                    state_d = StFetch;
                end
            end
            StFault: begin
                // Terminal: redirect and ack are ignored.
            end
            default: begin
                state_d = StFetch;
            end
        endcase

        // Reset overrides the combinational strobes so an outstanding request
        // is abandoned in the reset cycle itself.
        if (rst) begin
            pcW      = 1'b0;
            imem_req = 1'b0;
        end
    end

    // Redirect target only when it is actually being written; PC+4 otherwise,
    // which keeps next_pc deterministic even while pcW is low.
    assign next_pc   = (pcW && redirect) ? redirect_addr : pc_addr + 32'd4;
    assign imem_addr = pc_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StFetch;
            cnt_q         <= '0;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            instr_valid_q <= (state_d == StValid);
            fault_q       <= (state_d == StFault);
            if (latch_instr) begin
                instr_q    <= imem_rdata;
                instr_pc_q <= pc_addr;
            end
        end
    end

    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = instr_valid_q;
    assign fault       = fault_q;

endmodule
